// File: rtl/k005297_pkg.sv
// Shared types and constants for the K005297 cassette emulation layer.
package k005297_pkg;

  // Thermistor sense state as seen by the controller.
  typedef enum logic {
    TS_COLD = 1'b0,
    TS_WARM = 1'b1
  } temp_sense_t;

  // Default thermal model constants.
  localparam int DEF_TEMP_W    = 8;
  localparam int DEF_PRESCALE  = 4;
  localparam int DEF_HEAT_STEP = 2;
  localparam int DEF_COOL_STEP = 1;
  localparam int DEF_T_HI      = 10;
  localparam int DEF_T_LO      = 6;

  // True when the thresholds are ordered and fit the accumulator width.
  function automatic bit thermal_params_ok(input int temp_w, input int t_lo,
                                           input int t_hi, input int prescale);
    int tmax;
    if (temp_w < 1 || temp_w > 30) return 1'b0;
    tmax = (1 << temp_w) - 1;
    return (prescale >= 1) && (t_lo >= 0) && (t_lo < t_hi) && (t_hi <= tmax);
  endfunction

endpackage

// File: rtl/k005297_heatsim_prescaler.sv
// Enable-gated modulo counter. o_TICK_EN flags the enabled cycle on which the
// counter wraps; o_TICK is that event registered into a one-clock pulse.
module k005297_heatsim_prescaler #(
  parameter int MODULUS = 4
) (
  input  logic i_MCLK,
  input  logic i_RST,
  input  logic i_EN,
  output logic o_TICK_EN,
  output logic o_TICK
);

  localparam int CNT_W = (MODULUS > 1) ? $clog2(MODULUS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(MODULUS - 1);

  logic [CNT_W-1:0] cnt_q;
  logic             tick_q;

  assign o_TICK_EN = i_EN && (cnt_q == LAST);
  assign o_TICK    = tick_q;

  // Count enabled cycles, wrap at MODULUS-1; the pulse register runs every clock
  // so it drops after exactly one MCLK.
  always_ff @(posedge i_MCLK) begin
    if (i_RST) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      tick_q <= o_TICK_EN;
      if (i_EN) begin
        cnt_q <= o_TICK_EN ? '0 : cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/k005297_heatsim.sv
// Behavioural heater/thermistor model for the bubble cassette. Integrates the
// controller's heater drive into a saturating temperature and reports a
// hysteretic "temperature low" sense line back to the controller.
module k005297_heatsim
  import k005297_pkg::*;
#(
  parameter int TEMP_W    = DEF_TEMP_W,
  parameter int PRESCALE  = DEF_PRESCALE,
  parameter int HEAT_STEP = DEF_HEAT_STEP,
  parameter int COOL_STEP = DEF_COOL_STEP,
  parameter int T_HI      = DEF_T_HI,
  parameter int T_LO      = DEF_T_LO
) (
  input  logic              i_MCLK,
  input  logic              i_RST,
  input  logic              i_CLK4M_PCEN_n,
  input  logic              i_HEATEN_n,
  input  logic              i_FORCE_COLD,
  output logic              o_TEMPLO_n,
  output logic [TEMP_W-1:0] o_TEMP,
  output logic              o_TICK
);

  if (!thermal_params_ok(TEMP_W, T_LO, T_HI, PRESCALE)) begin : g_bad_params
    $error("k005297_heatsim: need T_LO < T_HI <= 2^TEMP_W-1 and PRESCALE >= 1");
  end

  localparam logic [TEMP_W-1:0] TEMP_MAX = '1;
  localparam logic [TEMP_W:0]   HEAT_INC = (TEMP_W + 1)'(HEAT_STEP);
  localparam logic [TEMP_W-1:0] COOL_DEC = TEMP_W'(COOL_STEP);
  localparam logic [TEMP_W-1:0] T_HI_V   = TEMP_W'(T_HI);
  localparam logic [TEMP_W-1:0] T_LO_V   = TEMP_W'(T_LO);

  logic              en;
  logic              tick_en;
  logic [1:0]        sync_q;
  logic              heat_on;
  logic [TEMP_W-1:0] temp_q;
  logic [TEMP_W-1:0] temp_d;
  logic [TEMP_W:0]   heat_sum;
  temp_sense_t       state_q;
  temp_sense_t       state_d;
  logic              templo_n_q;

  assign en      = ~i_CLK4M_PCEN_n;
  assign heat_on = ~sync_q[1];

  k005297_heatsim_prescaler #(
    .MODULUS (PRESCALE)
  ) u_prescaler (
    .i_MCLK    (i_MCLK),
    .i_RST     (i_RST),
    .i_EN      (en),
    .o_TICK_EN (tick_en),
    .o_TICK    (o_TICK)
  );

  // Two-stage synchroniser for the heater drive; resets to "heater off".
  always_ff @(posedge i_MCLK) begin
    if (i_RST) begin
      sync_q <= 2'b11;
    end else if (en) begin
      sync_q <= {sync_q[0], i_HEATEN_n};
    end
  end

  // Next temperature: saturating heat/cool on a tick, force-cold wins over both.
  always_comb begin
    heat_sum = {1'b0, temp_q} + HEAT_INC;
    temp_d   = temp_q;
    if (tick_en) begin
      if (heat_on) begin
        temp_d = heat_sum[TEMP_W] ? TEMP_MAX : heat_sum[TEMP_W-1:0];
      end else begin
        temp_d = (temp_q < COOL_DEC) ? '0 : temp_q - COOL_DEC;
      end
    end
    if (en && i_FORCE_COLD) begin
      temp_d = '0;
    end
  end

  // Temperature accumulator.
  always_ff @(posedge i_MCLK) begin
    if (i_RST) begin
      temp_q <= '0;
    end else begin
      temp_q <= temp_d;
    end
  end

  // Sense FSM state register.
  always_ff @(posedge i_MCLK) begin
    if (i_RST) begin
      state_q <= TS_COLD;
    end else begin
      state_q <= state_d;
    end
  end

  // Sense FSM next state: hysteresis band T_LO..T_HI-1 holds the current state.
  always_comb begin
    state_d = state_q;
    if (en) begin
      case (state_q)
        TS_COLD: if (temp_q >= T_HI_V) state_d = TS_WARM;
        TS_WARM: if (temp_q <  T_LO_V) state_d = TS_COLD;
        default: state_d = TS_COLD;
      endcase
    end
  end

  // Registered sense output, low while the cassette is cold.
  always_ff @(posedge i_MCLK) begin
    if (i_RST) begin
      templo_n_q <= 1'b0;
    end else begin
      templo_n_q <= (state_d == TS_WARM);
    end
  end

  assign o_TEMPLO_n = templo_n_q;
  assign o_TEMP     = temp_q;

endmodule

// File: tb/tb_k005297_heatsim.sv
// Directed bench for k005297_heatsim with default parameters. The clock enable
// is active on every second MCLK; each enabled cycle is one call of en_cycle.
module tb_k005297_heatsim;

  logic       i_MCLK = 1'b0;
  logic       i_RST;
  logic       i_CLK4M_PCEN_n;
  logic       i_HEATEN_n;
  logic       i_FORCE_COLD;
  logic       o_TEMPLO_n;
  logic [7:0] o_TEMP;
  logic       o_TICK;

  int   n_vec  = 0;
  int   n_fail = 0;
  int   en_idx = 0;
  logic tick_seen;

  // Clock and watchdog.
  always #5 i_MCLK = ~i_MCLK;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  k005297_heatsim dut (
    .i_MCLK         (i_MCLK),
    .i_RST          (i_RST),
    .i_CLK4M_PCEN_n (i_CLK4M_PCEN_n),
    .i_HEATEN_n     (i_HEATEN_n),
    .i_FORCE_COLD   (i_FORCE_COLD),
    .o_TEMPLO_n     (o_TEMPLO_n),
    .o_TEMP         (o_TEMP),
    .o_TICK         (o_TICK)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One enabled MCLK followed by one disabled MCLK; o_TICK captured in between.
  task automatic en_cycle();
    i_CLK4M_PCEN_n = 1'b0;
    @(posedge i_MCLK);
    #1;
    tick_seen = o_TICK;
    i_CLK4M_PCEN_n = 1'b1;
    @(posedge i_MCLK);
    #1;
    en_idx++;
  endtask

  task automatic idle_mclk(input int n);
    i_CLK4M_PCEN_n = 1'b1;
    repeat (n) @(posedge i_MCLK);
    #1;
  endtask

  initial begin
    bit         heat_dir [8];
    int         exp_t    [8];
    int         prev;
    int         guard;
    bit         mono_ok;
    logic [7:0] prev_t;

    heat_dir = '{1, 1, 0, 0, 1, 0, 0, 1};
    exp_t    = '{7, 9, 8, 7, 9, 8, 7, 9};

    // Reset with random inputs for three clocks.
    i_RST = 1'b1; i_CLK4M_PCEN_n = 1'b1; i_HEATEN_n = 1'b1; i_FORCE_COLD = 1'b0;
    repeat (3) begin
      i_CLK4M_PCEN_n = 1'($urandom_range(0, 1));
      i_HEATEN_n     = 1'($urandom_range(0, 1));
      i_FORCE_COLD   = 1'($urandom_range(0, 1));
      @(posedge i_MCLK);
      #1;
    end
    check("rst_templo", o_TEMPLO_n, 0);
    check("rst_temp", o_TEMP, 0);
    check("rst_tick", o_TICK, 0);

    // Warm-up: heater on from release; heat reaches the first tick (enable 4).
    i_RST = 1'b0; i_CLK4M_PCEN_n = 1'b1; i_FORCE_COLD = 1'b0; i_HEATEN_n = 1'b0;
    en_idx = 0;
    for (int k = 1; k <= 20; k++) begin
      en_cycle();
      check("warm_temp", o_TEMP, 2 * (k / 4));
      check("warm_templo", o_TEMPLO_n, 0);
      check("warm_tick", tick_seen, (k % 4 == 0));
    end
    en_cycle();
    check("warm_rise_templo", o_TEMPLO_n, 1);
    check("warm_rise_temp", o_TEMP, 10);

    // Cool-down through the hysteresis band: stays warm down to 6.
    i_HEATEN_n = 1'b1;
    for (int k = 22; k <= 40; k++) begin
      en_cycle();
      check("cool_temp", o_TEMP, 10 - (k / 4 - 5));
      check("cool_templo", o_TEMPLO_n, 1);
    end
    en_cycle();
    check("cool_fall_templo", o_TEMPLO_n, 0);
    check("cool_fall_temp", o_TEMP, 5);

    // Hysteresis hold: 7..9 while cold never raises the sense line.
    prev = 5;
    for (int b = 0; b < 8; b++) begin
      i_HEATEN_n = ~heat_dir[b];
      for (int j = 0; j < 4; j++) begin
        en_cycle();
        check("hyst_temp", o_TEMP, (j >= 2) ? exp_t[b] : prev);
        check("hyst_templo", o_TEMPLO_n, 0);
      end
      prev = exp_t[b];
    end

    // Saturation high: 200 ticks of heat.
    i_HEATEN_n = 1'b0;
    mono_ok = 1'b1;
    prev_t = o_TEMP;
    repeat (800) begin
      en_cycle();
      if (o_TEMP < prev_t) mono_ok = 1'b0;
      prev_t = o_TEMP;
    end
    check("sat_hi_temp", o_TEMP, 255);
    check("sat_hi_nowrap", mono_ok, 1);
    check("sat_hi_templo", o_TEMPLO_n, 1);

    // Saturation low: 300 ticks of cooling.
    i_HEATEN_n = 1'b1;
    mono_ok = 1'b1;
    prev_t = o_TEMP;
    repeat (1200) begin
      en_cycle();
      if (o_TEMP > prev_t) mono_ok = 1'b0;
      prev_t = o_TEMP;
    end
    check("sat_lo_temp", o_TEMP, 0);
    check("sat_lo_nowrap", mono_ok, 1);
    check("sat_lo_templo", o_TEMPLO_n, 0);

    // Heat to 12, then line up so the next enable is a tick.
    i_HEATEN_n = 1'b0;
    guard = 0;
    while (o_TEMP != 8'd12 && guard < 100) begin
      en_cycle();
      guard++;
    end
    check("force_reach12", o_TEMP, 12);
    while (en_idx % 4 != 3) en_cycle();
    check("force_pre_temp", o_TEMP, 12);
    check("force_pre_templo", o_TEMPLO_n, 1);

    // Disabled cycles ignore every input.
    i_FORCE_COLD = 1'b1; i_HEATEN_n = 1'b1;
    idle_mclk(6);
    check("idle_temp", o_TEMP, 12);
    check("idle_templo", o_TEMPLO_n, 1);
    check("idle_tick", o_TICK, 0);
    i_HEATEN_n = 1'b0;

    // Force-cold on a tick enable overrides the heat step.
    en_cycle();
    check("force_temp", o_TEMP, 0);
    check("force_templo_hold", o_TEMPLO_n, 1);
    check("force_tick", tick_seen, 1);
    i_FORCE_COLD = 1'b0;
    en_cycle();
    check("force_templo_fall", o_TEMPLO_n, 0);
    check("force_temp_after", o_TEMP, 0);

    // Reset mid-heat at temp 8, applied on a disabled clock.
    guard = 0;
    while (o_TEMP != 8'd8 && guard < 100) begin
      en_cycle();
      guard++;
    end
    check("rst2_reach8", o_TEMP, 8);
    i_CLK4M_PCEN_n = 1'b1;
    i_RST = 1'b1;
    @(posedge i_MCLK);
    #1;
    check("rst2_temp", o_TEMP, 0);
    check("rst2_templo", o_TEMPLO_n, 0);
    check("rst2_tick", o_TICK, 0);
    i_RST = 1'b0;
    en_idx = 0;

    // After reset, synchroniser and prescaler restart from their reset values.
    for (int k = 1; k <= 4; k++) begin
      en_cycle();
      check("rst2_heat_temp", o_TEMP, 2 * (k / 4));
      check("rst2_heat_tick", tick_seen, (k == 4));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
